// File: rtl/rti_pkg.sv
// Shared definitions for the RTI FIFO core and its consumers: the 128-bit
// entry layout (timestamp in the upper half, payload in the lower half)
// and the dispatcher state encoding.
package rti_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CAPTURE,
      WAIT
   } rti_disp_state_t;

   localparam int RTI_WIDTH = 128;
   localparam int TS_MSB    = 127;
   localparam int TS_LSB    = 64;
   localparam int DATA_MSB  = 63;
   localparam int DATA_LSB  = 0;

endpackage

// File: rtl/rti_timed_dispatcher.sv
// Timed dispatcher: pops one entry at a time from rti_core, parks it until
// the global counter equals its timestamp, then strobes the payload out.
// Entries whose timestamp has already passed when first compared are
// dropped and reported on late_error / late_error_data.
//
// FIFO handshake: read is a one-cycle pop request, raised only in READ,
// which is entered only after empty was sampled low. rti_core returns
// the entry one cycle later, which is the CAPTURE cycle.
module rti_timed_dispatcher
   import rti_pkg::*;
#(
   parameter int TS_WIDTH   = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic [TS_WIDTH-1:0]   counter,
   input  logic                  empty,
   input  logic [RTI_WIDTH-1:0]  rti_in,
   output logic                  read,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  late_error,
   output logic [RTI_WIDTH-1:0]  late_error_data,
   output logic                  busy
);

   rti_disp_state_t       state;
   logic [RTI_WIDTH-1:0]  entry_buf;
   logic [TS_WIDTH-1:0]   entry_ts;
   logic [DATA_WIDTH-1:0] entry_data;

   assign entry_ts   = entry_buf[TS_MSB -: TS_WIDTH];
   assign entry_data = entry_buf[DATA_LSB +: DATA_WIDTH];

   // Pop request and busy are decoded straight from the registered state,
   // so read is high for exactly the one READ cycle.
   assign read = (state == READ);
   assign busy = (state != IDLE);

   // Dispatch FSM with registered payload / error outputs; flush acts like
   // reset and overrides a fire or late drop due in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state           <= IDLE;
         entry_buf       <= '0;
         data_out        <= '0;
         data_valid      <= 1'b0;
         late_error      <= 1'b0;
         late_error_data <= '0;
      end else begin
         data_valid <= 1'b0;
         late_error <= 1'b0;
         case (state)
            IDLE: begin
               if (!empty) state <= READ;
            end
            READ: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               entry_buf <= rti_in;
               state     <= WAIT;
            end
            WAIT: begin
               // Only the WAIT cycles compare; an entry whose time passed
               // during READ/CAPTURE is resolved on the first WAIT cycle.
               if (counter >= entry_ts) begin
                  if (counter == entry_ts) begin
                     data_out   <= entry_data;
                     data_valid <= 1'b1;
                  end else begin
                     late_error_data <= entry_buf;
                     late_error      <= 1'b1;
                  end
                  state <= empty ? IDLE : READ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rti_timed_dispatcher.sv
// Bench for rti_timed_dispatcher. A queue stands in for rti_core (one-cycle
// read latency). For each case the expected read / fire / late cycles are
// computed from the timing rules with plain arithmetic on cycle numbers and
// counter values, then every output is compared every cycle.
module tb_rti_timed_dispatcher;
   import rti_pkg::*;

   logic         clk = 1'b0;
   logic         reset;
   logic         flush;
   logic [63:0]  counter;
   logic         empty;
   logic [127:0] rti_in;
   logic         read;
   logic [63:0]  data_out;
   logic         data_valid;
   logic         late_error;
   logic [127:0] late_error_data;
   logic         busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [127:0] fifo_q[$];
   logic [128:0] exp_q[$];   // {late, expected entry/payload} in dispatch order

   logic [63:0]  ent_ts[8];
   logic [63:0]  ent_data[8];

   // Clock
   always #5 clk = ~clk;

   rti_timed_dispatcher #(.TS_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clk             (clk),
      .reset           (reset),
      .flush           (flush),
      .counter         (counter),
      .empty           (empty),
      .rti_in          (rti_in),
      .read            (read),
      .data_out        (data_out),
      .data_valid      (data_valid),
      .late_error      (late_error),
      .late_error_data (late_error_data),
      .busy            (busy)
   );

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Clear the DUT (reset or flush for two edges), then load n entries
   // from ent_ts/ent_data and run with counter = base + cycle. A case with
   // abort_at >= 0 stops checking after that cycle; the next call's clear
   // then lands mid-flight.
   task automatic run_case(input bit use_flush, input logic [63:0] base, input int n, input int abort_at);
      int           rd_c[8];
      int           ev_c[8];
      bit           ev_late;
      int           r, w, d, last_c, k_ev;
      logic [63:0]  cw;
      logic [63:0]  m_data;
      logic [127:0] m_led;
      logic [128:0] ev;
      bit           read_prev, exp_read, exp_dv, exp_le, exp_busy;

      reset   = !use_flush;
      flush   = use_flush;
      empty   = 1'b1;
      counter = '0;
      rti_in  = '0;
      fifo_q.delete();
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check_eq("clr_read",       read,            0);
         check_eq("clr_busy",       busy,            0);
         check_eq("clr_data_valid", data_valid,      0);
         check_eq("clr_late_error", late_error,      0);
         check_eq("clr_data_out",   data_out,        0);
         check_eq("clr_late_data",  late_error_data, 0);
      end
      reset = 1'b0;
      flush = 1'b0;

      // Timeline: IDLE sees a non-empty FIFO in cycle 0, READ in cycle 1,
      // first compare two cycles after READ, outcome one cycle after decision,
      // next READ in that same outcome cycle.
      r = 1;
      for (int k = 0; k < n; k++) begin
         rd_c[k] = r;
         w  = r + 2;
         cw = base + 64'(w);
         if (cw > ent_ts[k]) begin
            d = w;
            ev_late = 1'b1;
         end else begin
            d = w + int'(ent_ts[k] - cw);
            ev_late = 1'b0;
         end
         ev_c[k] = d + 1;
         if (ev_late) exp_q.push_back({1'b1, ent_ts[k], ent_data[k]});
         else         exp_q.push_back({1'b0, 64'h0, ent_data[k]});
         r = d + 1;
         fifo_q.push_back({ent_ts[k], ent_data[k]});
      end
      last_c = (n == 0) ? 4 : ev_c[n-1] + 3;
      if (abort_at >= 0) last_c = abort_at;

      m_data    = '0;
      m_led     = '0;
      read_prev = 1'b0;
      k_ev      = 0;
      for (int c = 0; c <= last_c; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         counter = base + 64'(c);
         if (read_prev && fifo_q.size() > 0) rti_in = fifo_q.pop_front();
         empty = (fifo_q.size() == 0);

         exp_read = 1'b0;
         for (int k = 0; k < n; k++) if (rd_c[k] == c) exp_read = 1'b1;
         exp_dv = 1'b0;
         exp_le = 1'b0;
         if (k_ev < n && ev_c[k_ev] == c) begin
            ev = exp_q.pop_front();
            if (ev[128]) begin
               exp_le = 1'b1;
               m_led  = ev[127:0];
            end else begin
               exp_dv = 1'b1;
               m_data = ev[63:0];
            end
            k_ev++;
         end
         exp_busy = (n > 0) && (c >= 1) && (c <= ev_c[n-1] - 1);

         check_eq($sformatf("read@%0d", c),            read,            exp_read);
         check_eq($sformatf("busy@%0d", c),            busy,            exp_busy);
         check_eq($sformatf("data_valid@%0d", c),      data_valid,      exp_dv);
         check_eq($sformatf("late_error@%0d", c),      late_error,      exp_le);
         check_eq($sformatf("data_out@%0d", c),        data_out,        m_data);
         check_eq($sformatf("late_error_data@%0d", c), late_error_data, m_led);
         read_prev = read;
      end
      check_eq("dispatch_count", 128'(k_ev), (abort_at >= 0) ? 128'(k_ev) : 128'(n));
   endtask

   // Watchdog so the run always ends
   initial begin
      #5_000_000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      logic [63:0] base;
      int          n, off;

      reset = 1'b1; flush = 1'b0; empty = 1'b1; counter = '0; rti_in = '0;

      // Reset state, idle FIFO
      run_case(1'b0, 64'd0, 0, -1);

      // On-time dispatch: counter 90 at the read, fires at 100
      ent_ts[0] = 64'd100; ent_data[0] = 64'hDEAD_BEEF;
      run_case(1'b0, 64'd89, 1, -1);

      // Late drop
      ent_ts[0] = 64'd50; ent_data[0] = 64'h1234;
      run_case(1'b0, 64'd79, 1, -1);

      // Back-to-back, spacing 3
      ent_ts[0] = 64'd200; ent_data[0] = 64'hA;
      ent_ts[1] = 64'd203; ent_data[1] = 64'hB;
      run_case(1'b0, 64'd189, 2, -1);

      // Tight spacing: second entry late
      ent_ts[0] = 64'd300; ent_data[0] = 64'h300;
      ent_ts[1] = 64'd301; ent_data[1] = 64'h301;
      run_case(1'b0, 64'd289, 2, -1);

      // Flush mid-WAIT at counter 495 with ts=500 buffered (after one fire)
      ent_ts[0] = 64'd492; ent_data[0] = 64'h0492_0492;
      ent_ts[1] = 64'd500; ent_data[1] = 64'h0500_0500;
      run_case(1'b1, 64'd489, 2, 6);

      // Next entry after the flush runs normally
      ent_ts[0] = 64'd610; ent_data[0] = 64'h5555_AAAA_5555_AAAA;
      run_case(1'b1, 64'd600, 1, -1);

      // Randomized batches with wide timestamps
      for (int rnd = 0; rnd < 12; rnd++) begin
         n    = $urandom_range(1, 6);
         base = {32'($urandom), 32'($urandom_range(16, 32'h7fff_ffff))};
         off  = $urandom_range(0, 15);
         for (int k = 0; k < n; k++) begin
            ent_ts[k]   = base - 64'd4 + 64'(off);
            ent_data[k] = {32'($urandom), 32'($urandom)};
            off += $urandom_range(0, 10);
         end
         run_case(1'($urandom_range(0, 1)), base, n, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
